intprio: RTL

Multi-channel prioritised interrupt controller for the Nandy CPU, the parametrised successor to the single-line controller. It sits between the PC-increment logic and the PC register. It latches rising edges on up to NCHAN interrupt lines as pending bits and masks them per channel. At an instruction boundary it redirects the next PC to a per-channel vector, selecting the lowest-numbered ready channel. It also keeps the global enable and in-service state.

---
 rtl/intprio_pkg.sv | 21 ++
 rtl/intprio_prio_enc.sv | 26 ++
 rtl/intprio.sv | 91 +++++++++
 3 files changed

// File: rtl/intprio_pkg.sv
// intprio shared definitions: default vector base,
// per-channel vector computation and channel index width.
package intprio_pkg;

   localparam logic [15:0] DEF_VBASE = 16'h7F00;

   // Channel index width, never narrower than one bit
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Vector address of channel i; caller truncates to PC width
   function automatic logic [31:0] vector(
      input logic [31:0] base,
      input int unsigned i,
      input int unsigned shift
   );
      return base + (32'(i) << shift);
   endfunction

endpackage

// File: rtl/intprio_prio_enc.sv
// intprio lowest-index priority encoder.
// Gives the winning index and its one-hot form.
module prio_enc
   import intprio_pkg::*;
#(
   parameter int NCHAN = 4
) (
   input  logic [NCHAN-1:0]          req,
   output logic                      any,
   output logic [chan_w(NCHAN)-1:0]  idx,
   output logic [NCHAN-1:0]          onehot
);

   localparam int IW = chan_w(NCHAN);

   // Isolate the lowest set bit and find its index
   always_comb begin
      any    = |req;
      onehot = req & (~req + NCHAN'(1));
      idx    = '0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/intprio.sv
// intprio: multi-channel prioritised interrupt controller.
// Redirects the next PC to a channel vector at instruction boundaries.
module intprio
   import intprio_pkg::*;
#(
   parameter int              NCHAN  = 4,
   parameter int              PCW    = 16,
   parameter logic [PCW-1:0]  VBASE  = PCW'(DEF_VBASE),
   parameter int              VSHIFT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PCW-1:0]           pcin,
   input  logic [NCHAN-1:0]         irq,
   input  logic                     ncycle,
   input  logic                     nie,
   input  logic                     nid,
   input  logic                     nis,
   input  logic                     nic,
   input  logic                     nclr,
   input  logic                     nmw,
   input  logic [NCHAN-1:0]         mask_d,
   output logic [PCW-1:0]           pcout,
   output logic                     ienabled,
   output logic                     istatus,
   output logic [chan_w(NCHAN)-1:0] ichan,
   output logic [NCHAN-1:0]         pending
);

   localparam int IW = chan_w(NCHAN);

   logic [NCHAN-1:0] prev;
   logic [NCHAN-1:0] mask;
   logic [NCHAN-1:0] edges;
   logic [NCHAN-1:0] req;
   logic [NCHAN-1:0] win_oh;
   logic [IW-1:0]    win;
   logic             any;
   logic             ready;

   prio_enc #(
      .NCHAN (NCHAN)
   ) u_enc (
      .req    (req),
      .any    (any),
      .idx    (win),
      .onehot (win_oh)
   );

   // Edge detect, request gating and dispatch decision
   always_comb begin
      edges = irq & ~prev;
      req   = (pending | edges) & mask;
      ready = rst & ncycle & ienabled & ~istatus & any;
   end

   // Output mux: vector on dispatch, sequential PC otherwise
   always_comb begin
      pcout = pcin;
      if (ready) begin
         pcout = PCW'(vector(32'(VBASE), 32'(win), 32'(VSHIFT)));
      end
   end

   // Controller state, updated only at instruction boundaries
   always_ff @(posedge clk) begin
      if (!rst) begin
         prev     <= '0;
         pending  <= '0;
         mask     <= '1;
         ienabled <= 1'b0;
         istatus  <= 1'b0;
         ichan    <= '0;
      end else if (ncycle) begin
         prev    <= irq;
         pending <= (pending | edges) & ~(ready ? win_oh : '0);
         if (!nmw) mask <= mask_d;
         if (!nid)      ienabled <= 1'b0;
         else if (!nie) ienabled <= 1'b1;
         if (ready) begin
            istatus <= 1'b1;
            ichan   <= win;
         end else if (!nic || !nclr) begin
            istatus <= 1'b0;
         end else if (!nis) begin
            istatus <= 1'b1;
         end
      end
   end

endmodule
